// File: rtl/count_sequencer_if.sv
// Control and status bundle for count_sequencer: configuration, run/stop requests,
// count display and status flags.
interface count_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 4
);
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_limit;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_auto;
  logic             start;
  logic             stop;

  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             done;
  logic             wrap;
  logic             cfg_err;
  logic [1:0]       state_o;

  modport master (
    output cfg_we, cfg_limit, cfg_div, cfg_auto, start, stop,
    input  count_out, busy, done, wrap, cfg_err, state_o
  );

  modport slave (
    input  cfg_we, cfg_limit, cfg_div, cfg_auto, start, stop,
    output count_out, busy, done, wrap, cfg_err, state_o
  );
endinterface

// File: rtl/count_sequencer.sv
// Run/stop sequencer for the count register: programmable limit, prescaler,
// one-shot or auto-reload, pause/resume. All outputs come from registers.
module count_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  count_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [DIV_W-1:0] pre_q,   pre_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic             auto_q,  auto_d;
  logic             wrap_q,  wrap_d;
  logic             cfg_err_q, cfg_err_d;
  logic             tick;

  assign tick = (state_q == RUN) && (pre_q == div_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pre_d     = '0;
    limit_d   = limit_q;
    div_d     = div_q;
    auto_d    = auto_q;
    wrap_d    = 1'b0;
    cfg_err_d = bus.cfg_we && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (bus.cfg_we) begin
          limit_d = bus.cfg_limit;
          div_d   = bus.cfg_div;
          auto_d  = bus.cfg_auto;
        end
        if (bus.start && !bus.stop) state_d = RUN;
      end
      RUN: begin
        // stop outranks a coincident tick: count frozen, prescaler discarded
        if (bus.stop) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (count_q != limit_q) begin
            count_d = count_q + 1'b1;
          end else if (auto_q) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.start) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pre_q     <= '0;
      limit_q   <= '1;
      div_q     <= '0;
      auto_q    <= 1'b0;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      limit_q   <= limit_d;
      div_q     <= div_d;
      auto_q    <= auto_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.busy      = (state_q == RUN) || (state_q == PAUSE);
  assign bus.done      = (state_q == DONE);
  assign bus.wrap      = wrap_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Table-driven bench for count_sequencer: one vector per clock cycle, expected
// post-edge outputs queued when stimulus is applied and compared after the edge.
module tb_count_sequencer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct {
    logic       rst_n;
    logic       cfg_we;
    logic [3:0] lim;
    logic [3:0] dv;
    logic       au;
    logic       start;
    logic       stop;
    logic [3:0] exp_cnt;
    logic [1:0] exp_st;
    logic       exp_wrap;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  vec_t vecs[$];
  vec_t sb[$];

  count_sequencer_if #(.WIDTH(4), .DIV_W(4)) bus ();

  count_sequencer #(.WIDTH(4), .DIV_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rn, input logic we, input logic [3:0] lim,
                     input logic [3:0] dv, input logic au, input logic st,
                     input logic sp, input logic [3:0] ec, input logic [1:0] es,
                     input logic ew, input logic ee);
    vec_t v;
    v.rst_n = rn; v.cfg_we = we; v.lim = lim; v.dv = dv; v.au = au;
    v.start = st; v.stop = sp;
    v.exp_cnt = ec; v.exp_st = es; v.exp_wrap = ew; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic [3:0] ec, input logic [1:0] es, input logic ew);
    add(1, 0, 4'd0, 4'd0, 0, 0, 0, ec, es, ew, 0);
  endtask

  task automatic do_start(input logic [3:0] ec, input logic [1:0] es);
    add(1, 0, 4'd0, 4'd0, 0, 1, 0, ec, es, 0, 0);
  endtask

  task automatic do_stop(input logic [3:0] ec, input logic [1:0] es);
    add(1, 0, 4'd0, 4'd0, 0, 0, 1, ec, es, 0, 0);
  endtask

  task automatic chk(input int idx, input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL vec%0d %s: got %0d want %0d", idx, name, got, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_limit = '0; bus.cfg_div = '0;
    bus.cfg_auto = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;

    // reset, then stop alone and start+stop in IDLE are no-ops
    add(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, S_IDLE, 0, 0);
    add(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, S_IDLE, 0, 0);
    do_stop(4'd0, S_IDLE);
    add(1, 0, 4'd0, 4'd0, 0, 1, 1, 4'd0, S_IDLE, 0, 0);

    // reset defaults: limit 15, div 0, one-shot
    do_start(4'd0, S_RUN);
    for (int i = 1; i <= 15; i++) idle(4'(i), S_RUN, 0);
    idle(4'd15, S_DONE, 0);
    idle(4'd15, S_DONE, 0);
    add(1, 1, 4'd5, 4'd0, 0, 0, 0, 4'd15, S_DONE, 0, 1);
    idle(4'd15, S_DONE, 0);
    do_stop(4'd0, S_IDLE);

    // one-shot limit 5: done six edges after start
    add(1, 1, 4'd5, 4'd0, 0, 0, 0, 4'd0, S_IDLE, 0, 0);
    do_start(4'd0, S_RUN);
    for (int i = 1; i <= 5; i++) idle(4'(i), S_RUN, 0);
    idle(4'd5, S_DONE, 0);
    idle(4'd5, S_DONE, 0);
    do_start(4'd0, S_RUN);
    idle(4'd1, S_RUN, 0);
    do_stop(4'd1, S_PAUSE);
    do_stop(4'd0, S_IDLE);

    // prescaled auto-reload, config written together with start
    add(1, 1, 4'd2, 4'd3, 1, 1, 0, 4'd0, S_RUN, 0, 0);
    for (int i = 1; i <= 24; i++) idle(4'((i / 4) % 3), S_RUN, (i % 12) == 0);
    do_stop(4'd0, S_PAUSE);
    do_stop(4'd0, S_IDLE);

    // pause at 3 on a tick cycle, hold, resume after div+1
    add(1, 1, 4'd9, 4'd1, 0, 1, 0, 4'd0, S_RUN, 0, 0);
    for (int i = 1; i <= 7; i++) idle(4'(i / 2), S_RUN, 0);
    do_stop(4'd3, S_PAUSE);
    for (int i = 0; i < 10; i++) idle(4'd3, S_PAUSE, 0);
    do_start(4'd3, S_RUN);
    idle(4'd3, S_RUN, 0);
    idle(4'd4, S_RUN, 0);

    // start+stop in RUN pauses; config rejected in PAUSE
    add(1, 0, 4'd0, 4'd0, 0, 1, 1, 4'd4, S_PAUSE, 0, 0);
    add(1, 1, 4'd1, 4'd0, 1, 0, 0, 4'd4, S_PAUSE, 0, 1);
    idle(4'd4, S_PAUSE, 0);
    do_stop(4'd0, S_IDLE);
    do_start(4'd0, S_RUN);
    for (int i = 1; i <= 19; i++) idle(4'(i / 2), S_RUN, 0);
    idle(4'd9, S_DONE, 0);
    do_start(4'd0, S_RUN);
    idle(4'd0, S_RUN, 0);
    idle(4'd1, S_RUN, 0);

    // reset mid-run restores default configuration
    add(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, S_IDLE, 0, 0);
    add(0, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, S_IDLE, 0, 0);
    idle(4'd0, S_IDLE, 0);
    do_start(4'd0, S_RUN);
    for (int i = 1; i <= 3; i++) idle(4'(i), S_RUN, 0);
    do_stop(4'd3, S_PAUSE);
    do_stop(4'd0, S_IDLE);

    // limit 0 one-shot
    add(1, 1, 4'd0, 4'd0, 0, 0, 0, 4'd0, S_IDLE, 0, 0);
    do_start(4'd0, S_RUN);
    idle(4'd0, S_DONE, 0);
    idle(4'd0, S_DONE, 0);
    do_stop(4'd0, S_IDLE);

    // limit 0 auto-reload: wrap on every tick
    add(1, 1, 4'd0, 4'd1, 1, 1, 0, 4'd0, S_RUN, 0, 0);
    for (int i = 1; i <= 6; i++) idle(4'd0, S_RUN, (i % 2) == 0);
    do_stop(4'd0, S_PAUSE);
    do_stop(4'd0, S_IDLE);

    // limit 15 auto-reload, plus a rejected write in RUN
    add(1, 1, 4'd15, 4'd0, 1, 1, 0, 4'd0, S_RUN, 0, 0);
    for (int i = 1; i <= 18; i++) begin
      if (i == 5) add(1, 1, 4'd3, 4'd2, 0, 0, 0, 4'(i), S_RUN, 0, 1);
      else        idle(4'(i % 16), S_RUN, i == 16);
    end
    do_stop(4'd2, S_PAUSE);
    do_stop(4'd0, S_IDLE);

    for (int n = 0; n < vecs.size(); n++) begin
      vec_t v, e;
      v = vecs[n];
      rst_n         = v.rst_n;
      bus.cfg_we    = v.cfg_we;
      bus.cfg_limit = v.lim;
      bus.cfg_div   = v.dv;
      bus.cfg_auto  = v.au;
      bus.start     = v.start;
      bus.stop      = v.stop;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(n, "count_out", int'(bus.count_out), int'(e.exp_cnt));
      chk(n, "state_o",   int'(bus.state_o),   int'(e.exp_st));
      chk(n, "busy",      int'(bus.busy),      int'(e.exp_st == S_RUN || e.exp_st == S_PAUSE));
      chk(n, "done",      int'(bus.done),      int'(e.exp_st == S_DONE));
      chk(n, "wrap",      int'(bus.wrap),      int'(e.exp_wrap));
      chk(n, "cfg_err",   int'(bus.cfg_err),   int'(e.exp_err));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
